// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if
//   Bundles every bus signal around alu_share_ctrl: two request channels,
//   two response channels sharing one result bus, the registered ALU
//   operand bus, the ALU result inputs and the busy flag.
//   Modports:
//     slave  - the controller's view (takes requests, drives the ALU bus)
//     master - the surrounding logic's view (requesters plus the ALU instance)
//   Parameter W: datapath width of A/B/Y.
interface alu_share_ctrl_if #(
  parameter int W = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_A;
  logic [W-1:0] req0_B;
  logic [3:0]   req0_sel;
  logic         req0_Cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_A;
  logic [W-1:0] req1_B;
  logic [3:0]   req1_sel;
  logic         req1_Cin;

  logic         rsp0_valid;
  logic         rsp0_ready;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [W-1:0] rsp_Y;
  logic         rsp_Zero;

  logic [W-1:0] alu_A;
  logic [W-1:0] alu_B;
  logic [3:0]   alu_sel;
  logic         alu_Cin;
  logic [W-1:0] alu_Y;
  logic         alu_Zero;

  logic         busy;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_sel, req0_Cin,
    input  req1_valid, req1_A, req1_B, req1_sel, req1_Cin,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_Y, rsp_Zero,
    input  rsp0_ready, rsp1_ready,
    output alu_A, alu_B, alu_sel, alu_Cin,
    input  alu_Y, alu_Zero,
    output busy
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_sel, req0_Cin,
    output req1_valid, req1_A, req1_B, req1_sel, req1_Cin,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_Y, rsp_Zero,
    output rsp0_ready, rsp1_ready,
    input  alu_A, alu_B, alu_sel, alu_Cin,
    output alu_Y, alu_Zero,
    input  busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Time-shares one combinational ALU between two requesters. A winner is
//   picked in IDLE, its operands are registered onto the ALU inputs, the
//   controller waits ALU_LAT settle cycles, captures {Y, Zero} and returns
//   them on the winner's response channel. Transactions never overlap.
//   Ports:
//     CLK  - clock, all state changes on the rising edge
//     RST  - synchronous, active-high reset
//     bus  - alu_share_ctrl_if.slave: req0/req1 valid/ready + operands,
//            rsp0/rsp1 valid/ready, shared rsp_Y/rsp_Zero, registered
//            alu_A/B/sel/Cin, alu_Y/alu_Zero inputs, busy
//   Parameters:
//     ALU_LAT - settle cycles between driving the ALU and sampling it (1..15)
//     W       - datapath width
//   Build option:
//     ALU_SHARE_FIXED_PRIO_EN - when defined, requester 0 always wins a tie
//     and no last-grant pointer exists; default is round-robin.
module alu_share_ctrl #(
  parameter int ALU_LAT = 2,
  parameter int W       = 32
) (
  input logic            CLK,
  input logic            RST,
  alu_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

  state_t       state_q;
  state_t       state_d;
  logic [3:0]   cnt_q;
  logic         owner_q;

  logic         grant_vld;
  logic         grant_id;
  logic         accept;
  logic         rsp_rdy_own;

  logic [W-1:0] alu_a_p0;
  logic [W-1:0] alu_b_p0;
  logic [3:0]   alu_sel_p0;
  logic         alu_cin_p0;
  logic [W-1:0] rsp_y_p1;
  logic         rsp_zero_p1;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic         last_grant_q;
`endif

  // Arbitration: a lone requester wins outright; a tie goes to the
  // requester that was not served last (or always to 0 in fixed priority).
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_vld = 1'b1;
`ifdef ALU_SHARE_FIXED_PRIO_EN
      grant_id  = 1'b0;
`else
      grant_id  = ~last_grant_q;
`endif
    end else if (bus.req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (bus.req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.busy       = 1'b1;
    rsp_rdy_own    = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    unique case (state_q)
      IDLE: begin
        bus.busy       = 1'b0;
        bus.req0_ready = grant_vld && (grant_id == 1'b0);
        bus.req1_ready = grant_vld && (grant_id == 1'b1);
        accept         = grant_vld;
        if (grant_vld) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp0_valid = (owner_q == 1'b0);
        bus.rsp1_valid = (owner_q == 1'b1);
        if (rsp_rdy_own) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand stage (p0): winner's operands stay on the ALU bus until the
  // next accept, so the ALU sees stable inputs for the whole settle window.
  // Result stage (p1): Y/Zero are sampled on the last settle edge only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_a_p0     <= '0;
      alu_b_p0     <= '0;
      alu_sel_p0   <= '0;
      alu_cin_p0   <= 1'b0;
      rsp_y_p1     <= '0;
      rsp_zero_p1  <= 1'b0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      if (accept) begin
        alu_a_p0     <= grant_id ? bus.req1_A   : bus.req0_A;
        alu_b_p0     <= grant_id ? bus.req1_B   : bus.req0_B;
        alu_sel_p0   <= grant_id ? bus.req1_sel : bus.req0_sel;
        alu_cin_p0   <= grant_id ? bus.req1_Cin : bus.req0_Cin;
        owner_q      <= grant_id;
        cnt_q        <= CNT_LOAD;
`ifndef ALU_SHARE_FIXED_PRIO_EN
        last_grant_q <= grant_id;
`endif
      end
      if (state_q == EXEC) begin
        if (cnt_q == 4'd0) begin
          rsp_y_p1    <= bus.alu_Y;
          rsp_zero_p1 <= bus.alu_Zero;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  assign bus.alu_A    = alu_a_p0;
  assign bus.alu_B    = alu_b_p0;
  assign bus.alu_sel  = alu_sel_p0;
  assign bus.alu_Cin  = alu_cin_p0;
  assign bus.rsp_Y    = rsp_y_p1;
  assign bus.rsp_Zero = rsp_zero_p1;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        cin;
    logic [31:0] y;
    logic        z;
  } txn_t;

  typedef struct {
    int          own;
    logic [31:0] y;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy0, rdy1;
  logic ovr;
  logic [31:0] ovr_y;

  int tests  = 0;
  int failed = 0;

  txn_t q0[$];
  txn_t q1[$];
  exp_t sb[$];
  int   glog[$];

  always #5 clk = ~clk;

  alu_share_ctrl_if #(.W(32)) bus();

  alu_share_ctrl #(.ALU_LAT(2), .W(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // Stand-in ALU: add, subtract, one-hot shift, AND; ovr lets a test
  // force arbitrary values onto alu_Y to see exactly when it is sampled.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s, input logic c);
    case (s)
      4'b0110: return a + b + {31'd0, c};
      4'b0111: return a - b;
      4'b1110: return 32'd1 << a[4:0];
      default: return a & b;
    endcase
  endfunction

  assign bus.alu_Y      = ovr ? ovr_y : alu_fn(bus.alu_A, bus.alu_B, bus.alu_sel, bus.alu_Cin);
  assign bus.alu_Zero   = (bus.alu_Y == 32'd0);
  assign bus.rsp0_ready = rdy0;
  assign bus.rsp1_ready = rdy1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                              input logic c, input logic [31:0] y, input logic z);
    txn_t t;
    t.a = a; t.b = b; t.sel = s; t.cin = c; t.y = y; t.z = z;
    return t;
  endfunction

  task automatic chk_log(input string nm, input int n, input int g0, input int g1,
                         input int g2, input int g3);
    int e[4];
    e[0] = g0; e[1] = g1; e[2] = g2; e[3] = g3;
    chk({nm, "_len"}, glog.size(), n);
    for (int i = 0; i < n && i < glog.size(); i++)
      chk($sformatf("%s_grant%0d", nm, i), glog[i], e[i]);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bus.busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 200) begin
      failed++;
      $display("FAIL %s_timeout: got %0d cycles, want < 200", nm, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Requester 0 driver: presents the head of q0, retires it on accept and
  // records the expected response plus the grant order.
  initial begin
    logic acc;
    bus.req0_valid = 1'b0; bus.req0_A = '0; bus.req0_B = '0;
    bus.req0_sel = '0; bus.req0_Cin = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.req0_valid && bus.req0_ready && !rst;
      @(posedge clk);
      if (acc) begin
        txn_t t;
        exp_t e;
        t = q0.pop_front();
        e.own = 0; e.y = t.y; e.z = t.z;
        sb.push_back(e);
        glog.push_back(0);
      end
      #1;
      if (q0.size() != 0) begin
        bus.req0_valid = 1'b1; bus.req0_A = q0[0].a; bus.req0_B = q0[0].b;
        bus.req0_sel = q0[0].sel; bus.req0_Cin = q0[0].cin;
      end else begin
        bus.req0_valid = 1'b0;
      end
    end
  end

  // Requester 1 driver.
  initial begin
    logic acc;
    bus.req1_valid = 1'b0; bus.req1_A = '0; bus.req1_B = '0;
    bus.req1_sel = '0; bus.req1_Cin = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.req1_valid && bus.req1_ready && !rst;
      @(posedge clk);
      if (acc) begin
        txn_t t;
        exp_t e;
        t = q1.pop_front();
        e.own = 1; e.y = t.y; e.z = t.z;
        sb.push_back(e);
        glog.push_back(1);
      end
      #1;
      if (q1.size() != 0) begin
        bus.req1_valid = 1'b1; bus.req1_A = q1[0].a; bus.req1_B = q1[0].b;
        bus.req1_sel = q1[0].sel; bus.req1_Cin = q1[0].cin;
      end else begin
        bus.req1_valid = 1'b0;
      end
    end
  end

  // Response monitor: compares every completed response handshake
  // against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req0_ready && bus.req1_ready) begin
        tests++; failed++;
        $display("FAIL ready_excl: got both req readies high, want at most one");
      end
      if (bus.rsp0_valid && bus.rsp1_valid) begin
        tests++; failed++;
        $display("FAIL rsp_excl: got both rsp valids high, want at most one");
      end
      for (int n = 0; n < 2; n++) begin
        logic v, r;
        v = (n == 0) ? bus.rsp0_valid : bus.rsp1_valid;
        r = (n == 0) ? bus.rsp0_ready : bus.rsp1_ready;
        if (v && r) begin
          if (sb.size() == 0) begin
            tests++; failed++;
            $display("FAIL rsp_unexpected: got response on channel %0d, want none", n);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_owner", n, e.own);
            chk("rsp_Y", bus.rsp_Y, e.y);
            chk("rsp_Zero", 32'(bus.rsp_Zero), 32'(e.z));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1; ovr = 1'b0; ovr_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_aluA", bus.alu_A, 0);
    chk("rst_rspY", bus.rsp_Y, 0);
    chk("rst_rsp0v", 32'(bus.rsp0_valid), 0);
    chk("rst_rsp1v", 32'(bus.rsp1_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single request from requester 0, latency check
    q0.push_back(mk(32'd10, 32'd3367687, 4'b0110, 1'b0, 32'd3367697, 1'b0));
    @(negedge clk);
    chk("t1_req0_ready", 32'(bus.req0_ready), 1);
    chk("t1_req1_ready", 32'(bus.req1_ready), 0);
    @(negedge clk);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_aluA", bus.alu_A, 32'd10);
    chk("t1_aluB", bus.alu_B, 32'd3367687);
    chk("t1_rsp0v_e1", 32'(bus.rsp0_valid), 0);
    @(negedge clk);
    chk("t1_rsp0v_e2", 32'(bus.rsp0_valid), 0);
    @(negedge clk);
    chk("t1_rsp0v", 32'(bus.rsp0_valid), 1);
    chk("t1_rsp1v", 32'(bus.rsp1_valid), 0);
    wait_done("t1");

    // 2: both valid from reset, round-robin alternation
    do_reset();
    glog.delete();
    q0.push_back(mk(32'd254, 32'd244, 4'b0111, 1'b0, 32'd10, 1'b0));
    q1.push_back(mk(32'd5, 32'd0, 4'b1110, 1'b0, 32'h20, 1'b0));
    q0.push_back(mk(32'd100, 32'd1, 4'b0111, 1'b0, 32'd99, 1'b0));
    q1.push_back(mk(32'd3, 32'd0, 4'b1110, 1'b0, 32'd8, 1'b0));
    wait_done("t2");
    chk_log("t2", 4, 0, 1, 0, 1);

    // 3: response backpressure on requester 1 while requester 0 waits
    glog.delete();
    rdy1 = 1'b0;
    q1.push_back(mk(32'h80000000, 32'h80000000, 4'b0110, 1'b0, 32'd0, 1'b1));
    n = 0;
    while (!bus.busy && n < 20) begin @(negedge clk); n++; end
    chk("t3_busy_seen", 32'(n < 20), 1);
    q0.push_back(mk(32'd1, 32'd2, 4'b0110, 1'b0, 32'd3, 1'b0));
    n = 0;
    while (!bus.rsp1_valid && n < 20) begin @(negedge clk); n++; end
    chk("t3_rsp1v_seen", 32'(n < 20), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t3_rsp1v_%0d", i), 32'(bus.rsp1_valid), 1);
      chk($sformatf("t3_rspY_%0d", i), bus.rsp_Y, 0);
      chk($sformatf("t3_zero_%0d", i), 32'(bus.rsp_Zero), 1);
      chk($sformatf("t3_busy_%0d", i), 32'(bus.busy), 1);
      chk($sformatf("t3_req0v_%0d", i), 32'(bus.req0_valid), 1);
      chk($sformatf("t3_req0r_%0d", i), 32'(bus.req0_ready), 0);
    end
    @(posedge clk);
    #1 rdy1 = 1'b1;
    wait_done("t3");
    chk_log("t3", 2, 1, 0, 0, 0);

    // 4: ALU output glitches during the settle window; only the final
    //    settle edge may be sampled
    ovr = 1'b1;
    ovr_y = 32'hDEADBEEF;
    q0.push_back(mk(32'h000000FE, 32'd0, 4'b1111, 1'b0, 32'h2, 1'b0));
    @(negedge clk);
    chk("t4_req0_ready", 32'(bus.req0_ready), 1);
    @(negedge clk);
    ovr_y = 32'h00001234;
    chk("t4_aluA_e1", bus.alu_A, 32'hFE);
    @(negedge clk);
    ovr_y = 32'h00000002;
    chk("t4_aluA_e2", bus.alu_A, 32'hFE);
    @(negedge clk);
    ovr_y = 32'h00005555;
    chk("t4_aluA_resp", bus.alu_A, 32'hFE);
    chk("t4_rsp0v", 32'(bus.rsp0_valid), 1);
    wait_done("t4");
    ovr = 1'b0;

    // 5: reset on the second settle cycle aborts the transaction
    q0.push_back(mk(32'd7, 32'd8, 4'b0110, 1'b1, 32'd16, 1'b0));
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_e1", 32'(bus.busy), 1);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_aluA", bus.alu_A, 0);
    chk("t5_aluB", bus.alu_B, 0);
    chk("t5_alusel", 32'(bus.alu_sel), 0);
    chk("t5_alucin", 32'(bus.alu_Cin), 0);
    chk("t5_rspY", bus.rsp_Y, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t5_norsp_%0d", i), 32'(bus.rsp0_valid | bus.rsp1_valid), 0);
    end
    glog.delete();
    q0.push_back(mk(32'd1, 32'd1, 4'b0110, 1'b0, 32'd2, 1'b0));
    q1.push_back(mk(32'd2, 32'd2, 4'b0110, 1'b0, 32'd4, 1'b0));
    wait_done("t5");
    chk_log("t5", 2, 0, 1, 0, 0);

    // 6: both valid for several transactions; priority policy
    glog.delete();
    q0.push_back(mk(32'd1, 32'd1, 4'b0110, 1'b0, 32'd2, 1'b0));
    q0.push_back(mk(32'd2, 32'd2, 4'b0110, 1'b0, 32'd4, 1'b0));
    q0.push_back(mk(32'd3, 32'd3, 4'b0110, 1'b0, 32'd6, 1'b0));
    q1.push_back(mk(32'd9, 32'd0, 4'b0111, 1'b0, 32'd9, 1'b0));
    wait_done("t6");
`ifdef ALU_SHARE_FIXED_PRIO_EN
    chk_log("t6", 4, 0, 0, 0, 1);
`else
    chk_log("t6", 4, 0, 1, 0, 0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
